// File: rtl/audio_pkg.sv
// Shared definitions for the audio envelope detector: onset state
// encodings and the all-ones constant used to saturate magnitudes.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_HOLDOFF  = 2'd1,
    ST_WAIT_LOW = 2'd2
  } onset_state_t;

  // Widest sample supported; the top slices the saturation value it needs.
  localparam int                   MAG_MAX_W   = 32;
  localparam logic [MAG_MAX_W-1:0] MAG_SAT_ALL = '1;

endpackage

// File: rtl/onset_fsm.sv
// Onset detector: ARMED -> (env >= thr) pulse -> HOLDOFF for HOLDOFF updates
// -> WAIT_LOW until env drops below the hysteresis threshold -> ARMED.
// Only advances on envelope update strobes, so timing follows the sample rate.
module onset_fsm
  import audio_pkg::*;
#(
  parameter int W          = 15,
  parameter int HYST_SHIFT = 2,
  parameter int HOLDOFF    = 64
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_update,
  input  logic [W-1:0] i_env_new,
  input  logic [W-1:0] i_threshold,
  output logic         o_onset
);

  localparam int                CNT_W    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(HOLDOFF);

  onset_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_onset, w_onset_nxt;
  logic [W-1:0]     w_thr_lo;

  assign w_thr_lo = i_threshold - (i_threshold >> HYST_SHIFT);
  assign o_onset  = r_onset;

  // State, holdoff counter and registered onset pulse
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_ARMED;
      r_cnt   <= '0;
      r_onset <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_onset <= w_onset_nxt;
    end
  end

  // Next state; the onset pulse is only raised on an update, so it is
  // automatically 0 whenever the pipeline is stalled
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_onset_nxt = 1'b0;
    if (i_update) begin
      case (r_state)
        ST_ARMED: begin
          if (i_env_new >= i_threshold) begin
            w_onset_nxt = 1'b1;
            if (HOLDOFF == 0) begin
              w_state_nxt = ST_WAIT_LOW;
            end else begin
              w_state_nxt = ST_HOLDOFF;
              w_cnt_nxt   = CNT_INIT;
            end
          end
        end
        ST_HOLDOFF: begin
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = ST_WAIT_LOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        ST_WAIT_LOW: begin
          if (i_env_new < w_thr_lo) w_state_nxt = ST_ARMED;
        end
        default: begin
          w_state_nxt = ST_ARMED;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/audio_envelope_detector.sv
// Audio envelope detector: rectifies the high-pass sample stream, tracks an
// attack/release envelope and a peak-hold value, and emits one onset pulse per
// note. Two-stage pipeline driven only by the input strobe; enable low freezes it.
module audio_envelope_detector
  import audio_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 6,
  parameter int HYST_SHIFT    = 2,
  parameter int HOLDOFF       = 64
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_ready,
  input  logic [WIDTH-1:0] i_audio_in,
  input  logic [WIDTH-2:0] i_threshold,
  input  logic             i_peak_clear,
  output logic             o_env_ready,
  output logic [WIDTH-2:0] o_envelope,
  output logic [WIDTH-2:0] o_peak,
  output logic             o_onset
);

  localparam int            MW      = WIDTH - 1;
  localparam int            STAGES  = 2;
  localparam logic [MW-1:0] MAG_SAT = MAG_SAT_ALL[MW-1:0];

  logic [STAGES:1]  r_vld_pipe;
  logic [MW-1:0]    r_mag;
  logic [MW-1:0]    r_env;
  logic [MW-1:0]    r_peak;

  logic             w_update;
  logic [WIDTH-1:0] w_abs_full;
  logic [MW-1:0]    w_mag_in;
  logic [WIDTH-1:0] w_mag_x, w_env_x, w_diff, w_step, w_env_sum;
  logic [MW-1:0]    w_env_new;
  logic [MW-1:0]    w_peak_base, w_peak_new;

  // A stage-1 sample only advances into stage 2 while enabled
  assign w_update = i_enable & r_vld_pipe[1];

  // Rectify; only the most-negative input leaves the MSB set after negation
  always_comb begin
    w_abs_full = i_audio_in[WIDTH-1] ? (~i_audio_in + WIDTH'(1)) : i_audio_in;
    w_mag_in   = w_abs_full[WIDTH-1] ? MAG_SAT : w_abs_full[MW-1:0];
  end

  // Envelope step at full width: step is at most the gap, so no overshoot
  always_comb begin
    w_mag_x   = {1'b0, r_mag};
    w_env_x   = {1'b0, r_env};
    w_diff    = '0;
    w_step    = '0;
    w_env_sum = w_env_x;
    if (w_mag_x > w_env_x) begin
      w_diff = w_mag_x - w_env_x;
      w_step = w_diff >> ATTACK_SHIFT;
      if (w_step == '0) w_step = WIDTH'(1);
      w_env_sum = w_env_x + w_step;
    end else if (w_mag_x < w_env_x) begin
      w_diff = w_env_x - w_mag_x;
      w_step = w_diff >> RELEASE_SHIFT;
      if (w_step == '0) w_step = WIDTH'(1);
      w_env_sum = w_env_x - w_step;
    end
    w_env_new = w_env_sum[WIDTH-1] ? MAG_SAT : w_env_sum[MW-1:0];
  end

  // Peak: clear takes effect first, then the max with this sample's magnitude
  always_comb begin
    w_peak_base = i_peak_clear ? '0 : r_peak;
    w_peak_new  = (r_mag > w_peak_base) ? r_mag : w_peak_base;
  end

  // Pipeline valid bits, stage-1 magnitude, stage-2 envelope/peak
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_vld_pipe <= '0;
      r_mag      <= '0;
      r_env      <= '0;
      r_peak     <= '0;
    end else if (i_enable) begin
      r_vld_pipe <= {r_vld_pipe[1], i_ready};
      if (i_ready) r_mag <= w_mag_in;
      if (r_vld_pipe[1]) begin
        r_env  <= w_env_new;
        r_peak <= w_peak_new;
      end else if (i_peak_clear) begin
        r_peak <= '0;
      end
    end else begin
      // Stalled: stage-1 sample is kept, output strobe suppressed
      r_vld_pipe[STAGES] <= 1'b0;
    end
  end

  onset_fsm #(
    .W          (MW),
    .HYST_SHIFT (HYST_SHIFT),
    .HOLDOFF    (HOLDOFF)
  ) u_onset_fsm (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_update    (w_update),
    .i_env_new   (w_env_new),
    .i_threshold (i_threshold),
    .o_onset     (o_onset)
  );

  assign o_env_ready = r_vld_pipe[STAGES];
  assign o_envelope  = r_env;
  assign o_peak      = r_peak;

endmodule
